// File: rtl/parity_accumulator.sv
// Serial parity accumulator: collects FRAME_LEN valid bits per frame and
// reports their XOR and count of ones. Results update only on frame completion
// and hold until the next frame completes.
module parity_accumulator #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             parity,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             done,
    output logic             frame_err
);

    // Index only has to reach FRAME_LEN-1; keep it at least one bit wide.
    localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q;
    logic             acc_q;
    logic [CNT_W-1:0] ones_q;
    logic [IDX_W-1:0] idx_q;

    logic             acc_upd;
    logic [CNT_W-1:0] ones_upd;
    logic             last_bit;

    // Running values including the bit currently presented.
    always_comb begin
        acc_upd  = acc_q ^ bit_in;
        ones_upd = ones_q + CNT_W'(bit_in);
        last_bit = (idx_q == LAST_IDX);
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= 1'b0;
            ones_q    <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            parity    <= 1'b0;
            ones_cnt  <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Pulses default low; set only in the cycle they are meant for.
            done      <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // bit_valid is deliberately ignored while idle.
                    if (start) begin
                        state_q <= StAcc;
                        busy    <= 1'b1;
                        acc_q   <= 1'b0;
                        ones_q  <= '0;
                        idx_q   <= '0;
                    end
                end
                StAcc: begin
                    // A start during a frame is flagged but never disturbs it.
                    if (start) begin
                        frame_err <= 1'b1;
                    end
                    if (bit_valid) begin
                        if (last_bit) begin
                            state_q  <= StDone;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            parity   <= acc_upd;
                            ones_cnt <= ones_upd;
                        end else begin
                            acc_q  <= acc_upd;
                            ones_q <= ones_upd;
                            idx_q  <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        // Back-to-back frame: restart with cleared counters.
                        state_q <= StAcc;
                        busy    <= 1'b1;
                        acc_q   <= 1'b0;
                        ones_q  <= '0;
                        idx_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_accumulator.sv
// Randomised and directed bench for parity_accumulator (FRAME_LEN=8, CNT_W=4).
module tb_parity_accumulator;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             busy;
    logic             parity;
    logic [CNT_W-1:0] ones_cnt;
    logic             done;
    logic             frame_err;

    parity_accumulator #(
        .FRAME_LEN(FRAME_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .busy     (busy),
        .parity   (parity),
        .ones_cnt (ones_cnt),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    // Behavioural model: a frame is a list of collected bits; results are
    // derived from that list when it reaches FRAME_LEN entries.
    bit          in_frame  = 1'b0;
    bit          q[$];
    logic        exp_busy   = 1'b0;
    logic        exp_parity = 1'b0;
    logic [31:0] exp_ones   = 0;
    logic        exp_done   = 1'b0;
    logic        exp_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        in_frame   = 1'b0;
        q.delete();
        exp_busy   = 1'b0;
        exp_parity = 1'b0;
        exp_ones   = 0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic model_update(input logic s, input logic bv, input logic b);
        int n;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (in_frame) begin
            if (s) exp_err = 1'b1;
            if (bv) begin
                q.push_back(b);
                if (q.size() == FRAME_LEN) begin
                    n = 0;
                    foreach (q[i]) n += q[i];
                    exp_ones   = n;
                    exp_parity = n % 2;
                    exp_done   = 1'b1;
                    exp_busy   = 1'b0;
                    in_frame   = 1'b0;
                end
            end
        end else if (s) begin
            in_frame = 1'b1;
            q.delete();
            exp_busy = 1'b1;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("parity", 32'(parity), 32'(exp_parity));
        chk("ones_cnt", 32'(ones_cnt), exp_ones);
        chk("done", 32'(done), 32'(exp_done));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
    end

    task automatic cycle(input logic s, input logic bv, input logic b);
        start     = s;
        bit_valid = bv;
        bit_in    = b;
        @(posedge clk);
        model_update(s, bv, b);
        @(negedge clk);
        if (done === 1'b1) done_seen++;
    endtask

    // Sends bits[7] first.
    task automatic send_bits(input logic [7:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) cycle(1'b0, 1'b1, bits[7-i]);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_parity", 32'(parity), 0);
        chk("rst_ones", 32'(ones_cnt), 0);
        chk("rst_err", 32'(frame_err), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        // Reset state
        #2;
        chk("init_busy", 32'(busy), 0);
        chk("init_done", 32'(done), 0);
        chk("init_parity", 32'(parity), 0);
        chk("init_ones", 32'(ones_cnt), 0);
        chk("init_err", 32'(frame_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame 0,1,1,0,1,0,0,0
        cycle(1'b1, 1'b0, 1'b0);
        chk("basic_busy_acc", 32'(busy), 1);
        pat = 8'b0110_1000;
        done_seen = 0;
        send_bits(pat, 0, 7);
        chk("basic_done", 32'(done), 1);
        chk("basic_parity", 32'(parity), 1);
        chk("basic_ones", 32'(ones_cnt), 3);
        chk("basic_busy_done", 32'(busy), 0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("basic_done_drop", 32'(done), 0);
        chk("basic_hold", 32'(parity), 1);

        // Eight ones with 1-3 idle cycles between them
        cycle(1'b1, 1'b0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (i < 7) begin
                for (int g = 0; g < int'($urandom_range(3, 1)); g++)
                    cycle(1'b0, 1'b0, 1'($urandom_range(1, 0)));
            end
        end
        chk("gap_parity", 32'(parity), 0);
        chk("gap_ones", 32'(ones_cnt), 8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("gap_done_once", 32'(done_seen), 1);

        // Start while busy after 3rd bit
        cycle(1'b1, 1'b0, 1'b0);
        send_bits(pat, 0, 2);
        cycle(1'b1, 1'b0, 1'b0);
        chk("err_pulse", 32'(frame_err), 1);
        chk("err_busy", 32'(busy), 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("err_single", 32'(frame_err), 0);
        send_bits(pat, 3, 7);
        chk("err_done", 32'(done), 1);
        chk("err_parity", 32'(parity), 1);
        chk("err_ones", 32'(ones_cnt), 3);

        // Reset after 4 bits, then a clean frame 1,1,1,0,0,0,0,0
        cycle(1'b1, 1'b0, 1'b0);
        done_seen = 0;
        send_bits(8'b1111_1111, 0, 3);
        mid_reset();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("rst_no_done", 32'(done_seen), 0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rst_restart", 32'(busy), 1);
        send_bits(8'b1110_0000, 0, 7);
        chk("rst_frame_parity", 32'(parity), 1);
        chk("rst_frame_ones", 32'(ones_cnt), 3);

        // Back-to-back: 1,0,0,0,0,0,0,0 then all zeros
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        send_bits(8'b1000_0000, 0, 7);
        chk("b2b_first_ones", 32'(ones_cnt), 1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("b2b_busy", 32'(busy), 1);
        send_bits(8'b0000_0000, 0, 6);
        chk("b2b_hold_parity", 32'(parity), 1);
        chk("b2b_hold_ones", 32'(ones_cnt), 1);
        send_bits(8'b0000_0000, 7, 7);
        chk("b2b_parity", 32'(parity), 0);
        chk("b2b_ones", 32'(ones_cnt), 0);

        // Idle noise
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'($urandom_range(1, 0)));
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ones", 32'(ones_cnt), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(7, 0) == 0), ($urandom_range(3, 0) != 0),
                  1'($urandom_range(1, 0)));
            if ($urandom_range(499, 0) == 0) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
